// File: rtl/cpu_run_ctrl_pkg.sv
// Shared mode/command encodings for the run-mode controller, plus the
// command decoder that maps (code, current mode) to a target mode.
package cpu_run_ctrl_pkg;

   // Mode encodings are architecturally visible on mode_o.
   typedef enum logic [3:0] {
      MODE_FAULT = 4'd2,
      MODE_HALT  = 4'd4,
      MODE_RUN   = 4'd5,
      MODE_LOCK  = 4'd6,
      MODE_STEP  = 4'd7
   } mode_e;

   // Command / exception codes; 0 and 8..15 are ignored.
   localparam logic [3:0] EXC_RUN    = 4'd1;
   localparam logic [3:0] EXC_FAULT  = 4'd2;
   localparam logic [3:0] EXC_RESUME = 4'd3;
   localparam logic [3:0] EXC_HALT   = 4'd4;
   localparam logic [3:0] EXC_LOCK   = 4'd5;
   localparam logic [3:0] EXC_UNLOCK = 4'd6;
   localparam logic [3:0] EXC_STEP   = 4'd7;

   typedef struct packed {
      logic  accept;   // code applies in the current mode
      mode_e target;   // mode to enter when accepted
   } cmd_res_t;

   // Only one code arrives per cycle, so each code maps to exactly one rule.
   function automatic cmd_res_t decode_cmd(input logic [3:0] code,
                                           input mode_e      mode,
                                           input logic       step_n_nz);
      cmd_res_t r;
      r.accept = 1'b0;
      r.target = mode;
      case (code)
         EXC_FAULT:  if (mode != MODE_LOCK) begin
                        r.accept = 1'b1; r.target = MODE_FAULT;
                     end
         EXC_HALT:   if (mode != MODE_FAULT && mode != MODE_LOCK) begin
                        r.accept = 1'b1; r.target = MODE_HALT;
                     end
         EXC_RUN:    if (mode != MODE_LOCK) begin
                        r.accept = 1'b1; r.target = MODE_RUN;
                     end
         EXC_RESUME: if (mode != MODE_FAULT && mode != MODE_LOCK) begin
                        r.accept = 1'b1; r.target = MODE_RUN;
                     end
         EXC_UNLOCK: if (mode == MODE_LOCK || mode == MODE_RUN) begin
                        r.accept = 1'b1; r.target = MODE_RUN;
                     end
         EXC_LOCK:   begin
                        r.accept = 1'b1; r.target = MODE_LOCK;
                     end
         EXC_STEP:   if (mode == MODE_HALT && step_n_nz) begin
                        r.accept = 1'b1; r.target = MODE_STEP;
                     end
         default:    r.accept = 1'b0;
      endcase
      return r;
   endfunction

   // Codes that try to keep/return the core to RUN lose against a watchdog bite.
   function automatic logic wdt_overrides(input logic [3:0] code);
      return (code == EXC_RUN) || (code == EXC_RESUME) || (code == EXC_UNLOCK);
   endfunction

endpackage

// File: rtl/cpu_run_wdt.sv
// Watchdog: counts consecutive RUN cycles without a kick and flags expiry
// on the cycle the count reaches WDT_CYCLES. The parent turns the strobe
// into the FAULT transition and the registered wdt_fault_o pulse.
module cpu_run_wdt #(
   parameter int unsigned WDT_CYCLES = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   input  logic kick_i,
   output logic expire_o
);

   localparam int CW = $clog2(WDT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(WDT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Expiry strobe and next count; any non-RUN cycle or kick restarts counting.
   always_comb begin
      expire_o = run_i && !kick_i && (cnt_q == LAST);
      cnt_d    = cnt_q + CW'(1);
      if (!run_i || kick_i || expire_o) begin
         cnt_d = '0;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-mode controller: registered mode FSM driven by command codes, a
// clock-enable for the pipeline, N-cycle single step, optional watchdog
// and a wide enabled-cycle counter with sticky overflow.
// exc_valid_i qualifies exc_code_i for one cycle; there is no ready, every
// valid code is evaluated that cycle and either applied or dropped.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int          CNT_W      = 32,
   parameter int          STEP_W     = 16,
   parameter int unsigned WDT_CYCLES = 0,
   parameter int          RESET_MODE = 4   // HALT (4) or RUN (5)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              exc_valid_i,
   input  logic [3:0]        exc_code_i,
   input  logic [STEP_W-1:0] step_n_i,
   input  logic              clr_cnt_i,
   input  logic              wdt_kick_i,
   output logic              cpu_en_o,
   output logic [3:0]        mode_o,
   output logic [CNT_W-1:0]  cycle_cnt_o,
   output logic              cnt_ovf_o,
   output logic              step_done_o,
   output logic              wdt_fault_o
);

   localparam mode_e RST_MODE = mode_e'(4'(RESET_MODE));

   mode_e             mode_q, mode_d;
   logic [STEP_W-1:0] step_rem_q, step_rem_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              step_done_q, step_done_d;
   logic              wdt_fault_q, wdt_fault_d;
   logic              wdt_expire;
   logic              take_cmd;
   cmd_res_t          cmd;

   assign cpu_en_o    = (mode_q == MODE_RUN) || (mode_q == MODE_STEP);
   assign mode_o      = mode_q;
   assign cycle_cnt_o = cnt_q;
   assign cnt_ovf_o   = ovf_q;
   assign step_done_o = step_done_q;
   assign wdt_fault_o = wdt_fault_q;

   generate
      if (WDT_CYCLES > 0) begin : g_wdt
         cpu_run_wdt #(
            .WDT_CYCLES(WDT_CYCLES)
         ) u_wdt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .run_i   (mode_q == MODE_RUN),
            .kick_i  (wdt_kick_i),
            .expire_o(wdt_expire)
         );
      end else begin : g_no_wdt
         // Watchdog absent: the kick input has no effect.
         assign wdt_expire = wdt_kick_i & 1'b0;
      end
   endgenerate

   // Next mode, step countdown and pulses: commands first, then watchdog, then step expiry.
   always_comb begin
      mode_d      = mode_q;
      step_rem_d  = step_rem_q;
      step_done_d = 1'b0;
      wdt_fault_d = 1'b0;
      cmd         = decode_cmd(exc_code_i, mode_q, step_n_i != '0);
      take_cmd    = exc_valid_i && cmd.accept &&
                    !(wdt_expire && wdt_overrides(exc_code_i));
      if (take_cmd) begin
         mode_d     = cmd.target;
         step_rem_d = (cmd.target == MODE_STEP) ? step_n_i : '0;
      end else if (wdt_expire) begin
         mode_d      = MODE_FAULT;
         wdt_fault_d = 1'b1;
         step_rem_d  = '0;
      end else if (mode_q == MODE_STEP) begin
         step_rem_d = step_rem_q - STEP_W'(1);
         if (step_rem_q == STEP_W'(1)) begin
            mode_d      = MODE_HALT;
            step_done_d = 1'b1;
         end
      end
   end

   // Enabled-cycle counter; clear wins over increment in the same cycle.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_cnt_i) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (cpu_en_o) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (&cnt_q) begin
            ovf_d = 1'b1;
         end
      end
   end

   // State registers; reset returns everything to idle with no pulses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q      <= RST_MODE;
         step_rem_q  <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         step_done_q <= 1'b0;
         wdt_fault_q <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         step_rem_q  <= step_rem_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         step_done_q <= step_done_d;
         wdt_fault_q <= wdt_fault_d;
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl. Two instances share stimulus:
//   dut_a: CNT_W=32, no watchdog, reset into HALT
//   dut_b: CNT_W=4,  WDT_CYCLES=8, reset into RUN
// Every cycle both are compared with a behavioural model; directed
// sequences and a vector table add explicit expectations.
module tb_cpu_run_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [3:0]  code = 4'd0;
   logic [15:0] stepn = 16'd0;
   logic        clr = 1'b0;
   logic        kick = 1'b1;

   logic        a_en, a_ovf, a_done, a_fault;
   logic [3:0]  a_mode;
   logic [31:0] a_cnt;
   logic        b_en, b_ovf, b_done, b_fault;
   logic [3:0]  b_mode;
   logic [3:0]  b_cnt;

   int checks = 0;
   int failures = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   cpu_run_ctrl #(.CNT_W(32), .STEP_W(16), .WDT_CYCLES(0), .RESET_MODE(4)) dut_a (
      .clk_i(clk), .rst_i(rst), .exc_valid_i(valid), .exc_code_i(code),
      .step_n_i(stepn), .clr_cnt_i(clr), .wdt_kick_i(kick),
      .cpu_en_o(a_en), .mode_o(a_mode), .cycle_cnt_o(a_cnt), .cnt_ovf_o(a_ovf),
      .step_done_o(a_done), .wdt_fault_o(a_fault));

   cpu_run_ctrl #(.CNT_W(4), .STEP_W(16), .WDT_CYCLES(8), .RESET_MODE(5)) dut_b (
      .clk_i(clk), .rst_i(rst), .exc_valid_i(valid), .exc_code_i(code),
      .step_n_i(stepn), .clr_cnt_i(clr), .wdt_kick_i(kick),
      .cpu_en_o(b_en), .mode_o(b_mode), .cycle_cnt_o(b_cnt), .cnt_ovf_o(b_ovf),
      .step_done_o(b_done), .wdt_fault_o(b_fault));

   // ---------------- reference model ----------------
   typedef struct {
      int              mode;
      longint unsigned cnt;
      bit              ovf;
      int              rem;   // enabled step cycles still to go
      int              wdt;   // consecutive unkicked RUN cycles seen
      bit              done;
      bit              fault;
   } mstate_t;

   mstate_t ma, mb;

   function automatic mstate_t model_next(input mstate_t s, input int cnt_w,
                                          input int wdt_lim, input int rst_mode);
      mstate_t n;
      bit en, took, bite;
      int tgt;
      longint unsigned top;
      n = s;
      n.done = 0;
      n.fault = 0;
      if (rst) begin
         n.mode = rst_mode; n.cnt = 0; n.ovf = 0; n.rem = 0; n.wdt = 0;
         return n;
      end
      en  = (s.mode == 5) || (s.mode == 7);
      top = (64'd1 << cnt_w) - 64'd1;
      if (clr) begin
         n.cnt = 0; n.ovf = 0;
      end else if (en) begin
         if (s.cnt == top) begin n.cnt = 0; n.ovf = 1; end
         else n.cnt = s.cnt + 1;
      end
      took = 0;
      tgt  = s.mode;
      if (valid) begin
         case (int'(code))
            2: if (s.mode != 6) begin took = 1; tgt = 2; end
            4: if (s.mode != 2 && s.mode != 6) begin took = 1; tgt = 4; end
            1: if (s.mode != 6) begin took = 1; tgt = 5; end
            3: if (s.mode != 2 && s.mode != 6) begin took = 1; tgt = 5; end
            6: if (s.mode == 6 || s.mode == 5) begin took = 1; tgt = 5; end
            5: begin took = 1; tgt = 6; end
            7: if (s.mode == 4 && stepn != 0) begin took = 1; tgt = 7; end
            default: took = 0;
         endcase
      end
      bite  = (wdt_lim > 0) && (s.mode == 5) && !kick && (s.wdt + 1 == wdt_lim);
      n.wdt = (s.mode == 5 && !kick && !bite) ? s.wdt + 1 : 0;
      if (took && !(bite && (code == 4'd1 || code == 4'd3 || code == 4'd6))) begin
         n.mode = tgt;
         n.rem  = (tgt == 7) ? int'(stepn) : 0;
      end else if (bite) begin
         n.mode = 2; n.fault = 1;
      end else if (s.mode == 7) begin
         n.rem = s.rem - 1;
         if (s.rem == 1) begin n.mode = 4; n.done = 1; end
      end
      return n;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input longint unsigned act,
                      input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      chk("a_mode",  64'(a_mode),  64'(ma.mode));
      chk("a_en",    64'(a_en),    64'(ma.mode == 5 || ma.mode == 7));
      chk("a_cnt",   64'(a_cnt),   ma.cnt);
      chk("a_ovf",   64'(a_ovf),   64'(ma.ovf));
      chk("a_done",  64'(a_done),  64'(ma.done));
      chk("a_fault", 64'(a_fault), 64'(ma.fault));
      chk("b_mode",  64'(b_mode),  64'(mb.mode));
      chk("b_en",    64'(b_en),    64'(mb.mode == 5 || mb.mode == 7));
      chk("b_cnt",   64'(b_cnt),   mb.cnt);
      chk("b_ovf",   64'(b_ovf),   64'(mb.ovf));
      chk("b_done",  64'(b_done),  64'(mb.done));
      chk("b_fault", 64'(b_fault), 64'(mb.fault));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      ma = model_next(ma, 32, 0, 4);
      mb = model_next(mb, 4, 8, 5);
      #1;
      check_model();
   endtask

   task automatic cmd(input int c, input int sn);
      valid = 1'b1;
      code  = 4'(c);
      stepn = 16'(sn);
      tick();
      valid = 1'b0;
      stepn = 16'd0;
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit   v;
      int   c;
      int   sn;
      int   exp_mode;
      bit   exp_en;
   } vec_t;

   vec_t tbl[22];

   initial begin
      int en_cnt, done_cnt, fault_at, fault_cnt;

      tbl[0]  = '{1, 3, 0, 5, 1};   // RESUME from HALT
      tbl[1]  = '{1, 6, 0, 5, 1};   // UNLOCK while RUN stays RUN
      tbl[2]  = '{1, 7, 5, 5, 1};   // STEP only from HALT
      tbl[3]  = '{1, 2, 0, 2, 0};   // FAULT
      tbl[4]  = '{1, 4, 0, 2, 0};   // HALT blocked in FAULT
      tbl[5]  = '{1, 6, 0, 2, 0};   // UNLOCK blocked in FAULT
      tbl[6]  = '{1, 1, 0, 5, 1};   // RUN clears FAULT
      tbl[7]  = '{1, 4, 0, 4, 0};
      tbl[8]  = '{0, 2, 0, 4, 0};   // not valid -> ignored
      tbl[9]  = '{1, 0, 0, 4, 0};
      tbl[10] = '{1, 9, 0, 4, 0};
      tbl[11] = '{1, 15, 0, 4, 0};
      tbl[12] = '{1, 5, 0, 6, 0};   // LOCK
      tbl[13] = '{1, 7, 2, 6, 0};
      tbl[14] = '{1, 6, 0, 5, 1};   // UNLOCK from LOCK
      tbl[15] = '{1, 4, 0, 4, 0};
      tbl[16] = '{1, 7, 2, 7, 1};   // enter STEP
      tbl[17] = '{1, 1, 0, 5, 1};   // RUN leaves STEP
      tbl[18] = '{1, 4, 0, 4, 0};
      tbl[19] = '{1, 7, 4, 7, 1};
      tbl[20] = '{1, 5, 0, 6, 0};   // LOCK from STEP
      tbl[21] = '{1, 6, 0, 5, 1};

      // Reset, then idle: HALT, disabled, counter zero.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(10);
      chk("idle_mode", 64'(a_mode), 64'd4);
      chk("idle_en",   64'(a_en),   64'd0);
      chk("idle_cnt",  64'(a_cnt),  64'd0);

      // 100 RUN cycles then HALT; clear afterwards.
      cmd(1, 0);
      idle(99);
      cmd(4, 0);
      chk("run100_cnt",  64'(a_cnt),  64'd100);
      chk("run100_mode", 64'(a_mode), 64'd4);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_cnt", 64'(a_cnt), 64'd0);

      // 16 RUN cycles wrap the 4-bit counter.
      cmd(1, 0);
      idle(15);
      cmd(4, 0);
      chk("wrap_cnt_b", 64'(b_cnt), 64'd0);
      chk("wrap_ovf_b", 64'(b_ovf), 64'd1);
      chk("cnt16_a",    64'(a_cnt), 64'd16);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_ovf_b", 64'(b_ovf), 64'd0);

      // Three-cycle step burst.
      cmd(7, 3);
      en_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         en_cnt   += int'(a_en);
         done_cnt += int'(a_done);
         tick();
      end
      chk("step3_en_cycles", 64'(en_cnt),   64'd3);
      chk("step3_done",      64'(done_cnt), 64'd1);
      chk("step3_mode",      64'(a_mode),   64'd4);
      cmd(7, 0);
      chk("step0_mode", 64'(a_mode), 64'd4);

      // LOCK is only left through UNLOCK.
      cmd(5, 0); chk("lock_mode", 64'(a_mode), 64'd6);
      cmd(2, 0); chk("lock_fault", 64'(a_mode), 64'd6);
      cmd(4, 0); chk("lock_halt", 64'(a_mode), 64'd6);
      cmd(1, 0); chk("lock_run", 64'(a_mode), 64'd6);
      cmd(6, 0); chk("unlock", 64'(a_mode), 64'd5);
      cmd(2, 0); chk("fault", 64'(a_mode), 64'd2);
      cmd(3, 0); chk("fault_resume", 64'(a_mode), 64'd2);
      cmd(1, 0); chk("fault_run", 64'(a_mode), 64'd5);
      cmd(4, 0);

      // Watchdog: dut_b resets into RUN; no kick -> bite on the 8th cycle.
      kick = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      fault_at = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (b_fault && fault_at < 0) begin
            fault_at = i;
            chk("wdt_mode", 64'(b_mode), 64'd2);
         end
      end
      chk("wdt_fault_cycle", 64'(fault_at), 64'd8);

      // Kick every 5 cycles keeps RUN alive.
      cmd(1, 0);
      fault_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         kick = (i % 5 == 4);
         tick();
         fault_cnt += int'(b_fault);
      end
      chk("wdt_kicked_faults", 64'(fault_cnt), 64'd0);
      chk("wdt_kicked_mode",   64'(b_mode),    64'd5);
      kick = 1'b1;
      cmd(4, 0);

      // Reset in the middle of a step burst.
      cmd(7, 10);
      idle(3);
      rst = 1'b1;
      tick();
      chk("rst_step_mode",  64'(a_mode),  64'd4);
      chk("rst_step_en",    64'(a_en),    64'd0);
      chk("rst_step_cnt",   64'(a_cnt),   64'd0);
      chk("rst_step_ovf",   64'(a_ovf),   64'd0);
      chk("rst_step_done",  64'(a_done),  64'd0);
      chk("rst_step_mode_b", 64'(b_mode), 64'd5);
      rst = 1'b0;
      idle(2);
      chk("rst_step_no_done", 64'(a_done), 64'd0);

      // Vector table from a fresh reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 22; i++) begin
         valid = tbl[i].v;
         code  = 4'(tbl[i].c);
         stepn = 16'(tbl[i].sn);
         tick();
         chk($sformatf("tbl%0d_mode", i), 64'(a_mode), 64'(tbl[i].exp_mode));
         chk($sformatf("tbl%0d_en", i),   64'(a_en),   64'(tbl[i].exp_en));
      end
      valid = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         valid = ($urandom_range(0, 1) == 1);
         code  = 4'($urandom_range(0, 15));
         stepn = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 40))
                                             : 16'($urandom_range(0, 5));
         clr   = ($urandom_range(0, 49) == 0);
         kick  = ($urandom_range(0, 9) < 7);
         tick();
      end
      rst = 1'b0;
      valid = 1'b0;
      clr = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
